// File: rtl/if_id_stage.sv
// IF/ID pipeline register with flush/stall control and instruction field decode.
// Optional performance counters are enabled by defining IFID_PERF_CNT_EN.
module if_id_stage #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc_addr,
    input  logic [31:0]      instr_in,
    input  logic             stall,
    input  logic             flush,
    output logic [31:0]      instr,
    output logic [31:0]      pc_next,
    output logic             valid,
    output logic [1:0]       state,
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [31:0]      imm_ext,
    output logic [31:0]      jaddr
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StHold   = 2'b01,
        StBubble = 2'b10
    } state_e;

    state_e      state_q;
    logic [31:0] instr_q;
    logic [31:0] pc_next_q;
    logic        valid_q;

    // Pipeline register and control FSM: flush beats stall beats load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q   <= NOP_WORD;
            pc_next_q <= 32'd0;
            valid_q   <= 1'b0;
            state_q   <= StRun;
        end else if (flush) begin
            instr_q   <= NOP_WORD;
            pc_next_q <= 32'd0;
            valid_q   <= 1'b0;
            state_q   <= StBubble;
        end else if (stall) begin
            state_q   <= StHold;
        end else begin
            instr_q   <= instr_in;
            pc_next_q <= pc_addr + 32'd1;  // wraps to 0 at the top of the space
            valid_q   <= 1'b1;
            state_q   <= StRun;
        end
    end

    assign instr   = instr_q;
    assign pc_next = pc_next_q;
    assign valid   = valid_q;
    assign state   = state_q;

    assign opcode = instr_q[31:26];
    assign rs     = instr_q[25:21];
    assign rt     = instr_q[20:16];
    assign rd     = instr_q[15:11];
    assign shamt  = instr_q[10:6];
    assign funct  = instr_q[5:0];
    assign jaddr  = {6'b0, instr_q[25:0]};

    // Logical-immediate opcodes (andi/ori/xori) zero-extend; everything else sign-extends.
    always_comb begin
        if (opcode inside {6'h0C, 6'h0D, 6'h0E}) begin
            imm_ext = {16'h0000, instr_q[15:0]};
        end else begin
            imm_ext = {{16{instr_q[15]}}, instr_q[15:0]};
        end
    end

`ifdef IFID_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating event counters; a stall masked by a flush is not counted as a stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
            if (stall && !flush && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: the driver pushes hand-computed expectations,
// a separate monitor pops and compares them against the DUT outputs.
module tb_if_id_stage;

    localparam logic [31:0] NOP = 32'hFC00_0001;
    localparam int unsigned CW  = 2;

    localparam logic [1:0] RUN    = 2'b00;
    localparam logic [1:0] HOLD   = 2'b01;
    localparam logic [1:0] BUBBLE = 2'b10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_addr = '0;
    logic [31:0] instr_in = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instr, pc_next, imm_ext, jaddr;
    logic        valid;
    logic [1:0]  state;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
`ifdef IFID_PERF_CNT_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    if_id_stage #(
        .NOP_WORD (NOP),
        .CNT_W    (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pc_addr  (pc_addr),
        .instr_in (instr_in),
        .stall    (stall),
        .flush    (flush),
        .instr    (instr),
        .pc_next  (pc_next),
        .valid    (valid),
        .state    (state),
        .opcode   (opcode),
        .rs       (rs),
        .rt       (rt),
        .rd       (rd),
        .shamt    (shamt),
        .funct    (funct),
        .imm_ext  (imm_ext),
        .jaddr    (jaddr)
`ifdef IFID_PERF_CNT_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          st;
        logic [31:0] instr;
        logic [31:0] pcn;
        logic        valid;
        logic [1:0]  state;
        bit          dec;
        logic [5:0]  opc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [31:0] imm;
        bit          cnt;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    exp_t exp_q[$];
    event push_ev;
    int   checks = 0;
    int   failures = 0;

    task automatic cmp(input string nm, input string fld, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s.%s got=%h exp=%h", nm, fld, got, want);
        end
    endtask

    // Monitor: compares every pushed expectation against the current outputs.
    initial begin
        exp_t e;
        forever begin
            @(push_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.st) begin
                    cmp(e.name, "instr", instr, e.instr);
                    cmp(e.name, "pc_next", pc_next, e.pcn);
                    cmp(e.name, "valid", 32'(valid), 32'(e.valid));
                    cmp(e.name, "state", 32'(state), 32'(e.state));
                end
                if (e.dec) begin
                    cmp(e.name, "opcode", 32'(opcode), 32'(e.opc));
                    cmp(e.name, "rs", 32'(rs), 32'(e.rs));
                    cmp(e.name, "rt", 32'(rt), 32'(e.rt));
                    cmp(e.name, "rd", 32'(rd), 32'(e.rd));
                    cmp(e.name, "funct", 32'(funct), 32'(e.funct));
                    cmp(e.name, "imm_ext", imm_ext, e.imm);
                end
`ifdef IFID_PERF_CNT_EN
                if (e.cnt) begin
                    cmp(e.name, "stall_cnt", 32'(stall_cnt), e.scnt);
                    cmp(e.name, "flush_cnt", 32'(flush_cnt), e.fcnt);
                end
`endif
            end
        end
    end

    task automatic expect_st(input string nm, input logic [31:0] ins, input logic [31:0] pcn,
                             input logic v, input logic [1:0] s);
        exp_t e;
        e = '{name: nm, st: 1'b1, instr: ins, pcn: pcn, valid: v, state: s, default: '0};
        exp_q.push_back(e);
        ->push_ev;
    endtask

    task automatic expect_dec(input string nm, input logic [31:0] ins, input logic [31:0] pcn,
                              input logic [5:0] opc, input logic [4:0] r_s,
                              input logic [4:0] r_t, input logic [4:0] r_d,
                              input logic [5:0] fn, input logic [31:0] imm);
        exp_t e;
        e = '{name: nm, st: 1'b1, instr: ins, pcn: pcn, valid: 1'b1, state: RUN, dec: 1'b1,
              opc: opc, rs: r_s, rt: r_t, rd: r_d, funct: fn, imm: imm, default: '0};
        exp_q.push_back(e);
        ->push_ev;
    endtask

    task automatic expect_cnt(input string nm, input logic [31:0] sc, input logic [31:0] fc);
        exp_t e;
        e = '{name: nm, cnt: 1'b1, scnt: sc, fcnt: fc, default: '0};
        exp_q.push_back(e);
        ->push_ev;
    endtask

    // Drive one cycle of inputs, then return 1ns after the capturing edge.
    task automatic step(input logic [31:0] pc, input logic [31:0] ins, input logic st,
                        input logic fl);
        pc_addr  = pc;
        instr_in = ins;
        stall    = st;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    // Reset pulse placed between edges; outputs are checked while reset is high.
    task automatic pulse_reset(input string nm);
        reset = 1'b1;
        #1;
        expect_st(nm, NOP, 32'd0, 1'b0, RUN);
`ifdef IFID_PERF_CNT_EN
        expect_cnt(nm, 32'd0, 32'd0);
`endif
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        pulse_reset("reset");

        step(32'd5, 32'h2128_000A, 1'b0, 1'b0);
        expect_dec("load_addi", 32'h2128_000A, 32'd6, 6'h08, 5'd9, 5'd8, 5'd0, 6'h0A,
                   32'h0000_000A);
        step(32'd6, 32'h3108_FFFF, 1'b0, 1'b0);
        expect_dec("andi_zext", 32'h3108_FFFF, 32'd7, 6'h0C, 5'd8, 5'd8, 5'd31, 6'h3F,
                   32'h0000_FFFF);
        step(32'd7, 32'h2108_FFFF, 1'b0, 1'b0);
        expect_dec("addi_sext", 32'h2108_FFFF, 32'd8, 6'h08, 5'd8, 5'd8, 5'd31, 6'h3F,
                   32'hFFFF_FFFF);
        step(32'd8, 32'h3400_8000, 1'b0, 1'b0);
        expect_dec("ori_zext", 32'h3400_8000, 32'd9, 6'h0D, 5'd0, 5'd0, 5'd16, 6'h00,
                   32'h0000_8000);
        step(32'd9, 32'h3800_8000, 1'b0, 1'b0);
        expect_dec("xori_zext", 32'h3800_8000, 32'd10, 6'h0E, 5'd0, 5'd0, 5'd16, 6'h00,
                   32'h0000_8000);
        step(32'd10, 32'h3C00_8000, 1'b0, 1'b0);
        expect_dec("lui_sext", 32'h3C00_8000, 32'd11, 6'h0F, 5'd0, 5'd0, 5'd16, 6'h00,
                   32'hFFFF_8000);

        step(32'd20, 32'hAAAA_0001, 1'b1, 1'b0);
        expect_st("stall1", 32'h3C00_8000, 32'd11, 1'b1, HOLD);
        step(32'd21, 32'hAAAA_0002, 1'b1, 1'b0);
        expect_st("stall2", 32'h3C00_8000, 32'd11, 1'b1, HOLD);
        step(32'd22, 32'hAAAA_0003, 1'b1, 1'b0);
        expect_st("stall3", 32'h3C00_8000, 32'd11, 1'b1, HOLD);
        step(32'd23, 32'h0000_1234, 1'b0, 1'b0);
        expect_st("stall_release", 32'h0000_1234, 32'd24, 1'b1, RUN);

        step(32'd30, 32'h1111_1111, 1'b1, 1'b1);
        expect_st("flush_and_stall", NOP, 32'd0, 1'b0, BUBBLE);
        step(32'd31, 32'h2222_2222, 1'b0, 1'b0);
        expect_st("bubble_to_run", 32'h2222_2222, 32'd32, 1'b1, RUN);

        step(32'd50, 32'h5555_5555, 1'b1, 1'b0);
        expect_st("hold_pre_reset", 32'h2222_2222, 32'd32, 1'b1, HOLD);
        pulse_reset("reset_in_hold");
        step(32'hFFFF_FFFF, 32'h0000_0020, 1'b0, 1'b0);
        expect_st("pc_wrap", 32'h0000_0020, 32'd0, 1'b1, RUN);

        step(32'd60, 32'h6666_6666, 1'b0, 1'b1);
        expect_st("flush_a", NOP, 32'd0, 1'b0, BUBBLE);
        step(32'd61, 32'h7777_7777, 1'b0, 1'b1);
        expect_st("flush_repeat", NOP, 32'd0, 1'b0, BUBBLE);
        step(32'd62, 32'h8888_8888, 1'b1, 1'b0);
        expect_st("bubble_to_hold", NOP, 32'd0, 1'b0, HOLD);
        step(32'd63, 32'h9999_9999, 1'b0, 1'b0);
        expect_st("hold_to_run", 32'h9999_9999, 32'd64, 1'b1, RUN);

        pulse_reset("reset_cnt");
        step(32'd70, 32'h1, 1'b0, 1'b1);
        step(32'd71, 32'h2, 1'b0, 1'b1);
        expect_st("bubble_pre_reset", NOP, 32'd0, 1'b0, BUBBLE);
`ifdef IFID_PERF_CNT_EN
        expect_cnt("flush_cnt2", 32'd0, 32'd2);
`endif
        pulse_reset("reset_in_bubble");
        for (int i = 0; i < 5; i++) begin
            step(32'd80 + 32'(i), 32'hABCD_0000 + 32'(i), 1'b1, 1'b0);
        end
        expect_st("hold_after_reset", NOP, 32'd0, 1'b0, HOLD);
`ifdef IFID_PERF_CNT_EN
        expect_cnt("stall_cnt_sat", 32'd3, 32'd0);
`endif

        #20;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter NOP_WORD, default 32'h0000_0000, the instruction word inserted on flush.
REQ-002 SHALL have parameter CNT_W, default 16, the performance counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port pc_addr  input  32  word address of the instruction being fetched, from the program counter.
REQ-006 SHALL have port instr_in  input  32  instruction word read from instruction memory at pc_addr.
REQ-007 SHALL have port stall  input  1  hazard hold request.
REQ-008 SHALL have port flush  input  1  taken branch or jump; discard the fetched instruction.
REQ-009 SHALL have port instr  output  32  registered instruction.
REQ-010 SHALL have port pc_next  output  32  registered pc_addr+1.
REQ-011 SHALL have port valid  output  1  registered instruction is real, not a bubble.
REQ-012 SHALL have port state  output  2  FSM state: RUN=00, HOLD=01, BUBBLE=10.
REQ-013 SHALL have ports opcode 6, rs 5, rt 5, rd 5, shamt 5, funct 6 (all outputs), decoded from instr.
REQ-014 SHALL have port imm_ext  output  32  extended instr[15:0].
REQ-015 SHALL have port jaddr  output  32  {6'b0, instr[25:0]}, a jump word address.

Function
REQ-016 SHALL evaluate per posedge with priority flush > stall > load.
REQ-017 Load (neither flush nor stall) SHALL capture instr<=instr_in, pc_next<=pc_addr+1 (mod 2^32), valid<=1, state<=RUN.
REQ-018 Flush SHALL set instr<=NOP_WORD, pc_next<=0, valid<=0, state<=BUBBLE, regardless of stall.
REQ-019 Stall without flush SHALL hold instr, pc_next and valid unchanged, with state<=HOLD.
REQ-020 BUBBLE SHALL last exactly one cycle unless flush repeats; it SHALL then go to HOLD on stall, otherwise RUN with load.
REQ-021 HOLD SHALL persist while stall=1; the first cycle with stall=0 SHALL load and go to RUN.
REQ-022 Decoded fields SHALL be combinational from instr: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0].
REQ-023 imm_ext SHALL zero-extend for opcodes 6'h0C, 6'h0D, 6'h0E and sign-extend for all other opcodes.
REQ-024 pc_addr=32'hFFFF_FFFF SHALL yield pc_next=0, with no error flag.
REQ-025 Every output SHALL reach its final value within one clock of the triggering edge; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-026 Reset assertion SHALL immediately set instr=NOP_WORD, pc_next=0, valid=0, state=RUN and counters=0, independent of clk.
REQ-027 Reset asserted mid-stall or mid-bubble SHALL abandon that state.
REQ-028 The first posedge after deassertion SHALL follow REQ-016.

Configuration
REQ-029 With IFID_PERF_CNT_EN defined, the block SHALL add outputs stall_cnt[CNT_W-1:0] and flush_cnt[CNT_W-1:0].
REQ-030 Under IFID_PERF_CNT_EN, stall_cnt SHALL increment on each posedge with stall=1 and flush=0, and flush_cnt on each posedge with flush=1.
REQ-031 Under IFID_PERF_CNT_EN, both counters SHALL saturate at all-ones.
REQ-032 Without IFID_PERF_CNT_EN, these ports and this logic SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-033 Reset, then pc_addr=5, instr_in=32'h2128_000A -> next edge: instr=32'h2128_000A, pc_next=6, valid=1, opcode=6'h08, rs=9, rt=8, imm_ext=10.
REQ-034 Load 32'h3108_FFFF, then load 32'h2108_FFFF -> imm_ext=32'h0000_FFFF, then 32'hFFFF_FFFF.
REQ-035 Stall=1 for 3 cycles while instr_in changes -> instr unchanged, state=HOLD; the edge after release loads the current instr_in.
REQ-036 Flush=1 and stall=1 on the same edge -> instr=NOP_WORD, valid=0, state=BUBBLE; the next edge with both low gives state=RUN, valid=1.
REQ-037 pc_addr=32'hFFFF_FFFF load -> pc_next=0.
REQ-038 Reset pulsed between edges during HOLD -> outputs at reset values before the next edge.
REQ-039 With IFID_PERF_CNT_EN and CNT_W=2: 5 stall cycles -> stall_cnt=3 (saturated); 2 flush cycles -> flush_cnt=2.
